rr_stream_mux: RTL and testbench

Parametrised, registered N-channel stream multiplexer. It is the successor to the team's combinational 4:1 mux. Each of N_CH input channels carries WIDTH-bit data with a valid/ready handshake. A round-robin or fixed-select arbiter picks one channel per transfer and registers it into a single output stage. The block sits between multiple producer streams and one shared downstream consumer.

---
 rtl/mux_pkg.sv | 9 +
 rtl/rr_stream_mux_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/rr_stream_mux.sv | 84 ++++++++
 tb/tb_rr_stream_mux.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin stream multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/rr_stream_mux_if.sv
// Bundles the N-channel input streams, mode controls and single output stream.
interface rr_stream_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) ();

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel_fixed;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;

    // Producers/consumer side
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output mode,
        output sel_fixed,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_ch
    );

    // Multiplexer side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  mode,
        input  sel_fixed,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr+1, or a single fixed channel.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_fixed,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        if (mode == MODE_FIXED) begin
            // Out-of-range selects match no channel, so nothing is granted
            for (int i = 0; i < N_CH; i++) begin
                if (!any_grant && req[i] && (sel_fixed == SEL_W'(i))) begin
                    any_grant = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                cand = SEL_W'((int'(ptr) + k) % N_CH);
                if (!any_grant && req[cand]) begin
                    any_grant = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign grant[gi] = any_grant && (grant_idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with one registered output stage and
// round-robin or fixed-select arbitration.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_stream_mux_if.slave bus
);

    localparam int SEL_W = $clog2(N_CH);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             any_grant;
    logic             load_en;

    logic [WIDTH-1:0] out_data_reg,  out_data_next;
    logic [SEL_W-1:0] out_ch_reg,    out_ch_next;
    logic             out_valid_reg, out_valid_next;
    logic [SEL_W-1:0] ptr_reg,       ptr_next;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (ptr_reg),
        .mode      (bus.mode),
        .sel_fixed (bus.sel_fixed),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Output stage can take a word when empty or being drained this cycle
    assign load_en      = !out_valid_reg || bus.out_ready;
    assign bus.in_ready = grant & {N_CH{load_en & rst_n}};

    always_comb begin
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (load_en) begin
            out_valid_next = any_grant;
            if (any_grant) begin
                out_data_next = ch_data[grant_idx];
                out_ch_next   = grant_idx;
                ptr_next      = grant_idx;
            end
        end
    end

    // ptr resets to the last channel so channel 0 wins the first arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= SEL_W'(N_CH - 1);
        end else begin
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed self-checking bench for rr_stream_mux (N_CH=4, WIDTH=8).
module tb_rr_stream_mux;
    import mux_pkg::*;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    rr_stream_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] ch);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(d));
        chk({tag, ".out_ch"},    32'(bus.out_ch),    32'(ch));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sw_d  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] sw_ch [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] sw_rdy[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] sp_d  [4] = '{8'h22, 8'h44, 8'h22, 8'h44};
    logic [1:0] sp_ch [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [3:0] sp_rdy[4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    initial begin
        rst_n         = 1'b1;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = 4'hF;
        bus.mode      = MODE_RR;
        bus.sel_fixed = 2'd0;
        bus.out_ready = 1'b1;

        // Power-on reset, asserted mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk_out("por", 1'b0, 8'h00, 2'd0);
        chk("por.in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("first_arb.in_ready", 32'(bus.in_ready), 32'b0001);

        // Round-robin sweep, all channels valid
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("sweep%0d", i), 1'b1, sw_d[i], sw_ch[i]);
            chk($sformatf("sweep%0d.in_ready", i), 32'(bus.in_ready), 32'(sw_rdy[i]));
        end

        // Sparse requests on channels 1 and 3
        bus.in_valid = 4'b1010;
        #1;
        chk("sparse.in_ready0", 32'(bus.in_ready), 32'b0010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("sparse%0d", i), 1'b1, sp_d[i], sp_ch[i]);
            chk($sformatf("sparse%0d.in_ready", i), 32'(bus.in_ready), 32'(sp_rdy[i]));
        end

        // Backpressure while holding 8'h22
        bus.in_valid = 4'hF;
        tick();
        chk_out("bp_pre0", 1'b1, 8'h11, 2'd0);
        tick();
        chk_out("bp_pre1", 1'b1, 8'h22, 2'd1);
        bus.out_ready = 1'b0;
        #1;
        chk("bp.in_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1'b1, 8'h22, 2'd1);
            chk($sformatf("bp_hold%0d.in_ready", i), 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        chk_out("bp_next", 1'b1, 8'h33, 2'd2);

        // Fixed select on channel 2
        bus.mode      = MODE_FIXED;
        bus.sel_fixed = 2'd2;
        #1;
        chk("fixed.in_ready0", 32'(bus.in_ready), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("fixed%0d", i), 1'b1, 8'h33, 2'd2);
            chk($sformatf("fixed%0d.in_ready", i), 32'(bus.in_ready), 32'b0100);
        end
        bus.sel_fixed = 2'd3;
        bus.in_valid  = 4'b0111;
        #1;
        chk("fixed_idle.in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        chk_out("fixed_drain", 1'b0, 8'h33, 2'd2);

        // Mode switch during a stall
        bus.mode     = MODE_RR;
        bus.in_valid = 4'hF;
        #1;
        chk("msw.in_ready0", 32'(bus.in_ready), 32'b1000);
        tick();
        chk_out("msw_load", 1'b1, 8'h44, 2'd3);
        bus.out_ready = 1'b0;
        bus.mode      = MODE_FIXED;
        bus.sel_fixed = 2'd1;
        #1;
        chk("msw_stall.in_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("msw_hold%0d", i), 1'b1, 8'h44, 2'd3);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("msw_release.in_ready", 32'(bus.in_ready), 32'b0010);
        tick();
        chk_out("msw_after", 1'b1, 8'h22, 2'd1);

        // Asynchronous reset in the middle of a transfer
        bus.mode = MODE_RR;
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 2'd0);
        chk("mid_rst.in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        chk_out("mid_rst_edge", 1'b0, 8'h00, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst.in_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk_out("post_rst", 1'b1, 8'h11, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
